// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter
// Two-master WISHBONE arbiter merging the ao68000 CPU bus (m0) and the DMA
// master (m1) onto the shared slave bus. Round-robin grant with a mandatory
// IDLE cycle between owners, combinational return path to the owner only,
// and a watchdog that terminates unanswered strobes with a one-cycle ERR.

module wb_master_arbiter #(
   parameter int unsigned TIMEOUT = 255   // legal range 2..65535
) (
   input  logic        CLK_I,
   input  logic        reset_n,

   // master 0: ao68000 CPU
   input  logic [29:0] m0_ADR_I,
   input  logic        m0_CYC_I,
   input  logic        m0_STB_I,
   input  logic        m0_WE_I,
   input  logic [3:0]  m0_SEL_I,
   input  logic [31:0] m0_DAT_I,
   input  logic        m0_cpu_space,
   output logic [31:0] m0_DAT_O,
   output logic        m0_ACK_O,
   output logic        m0_RTY_O,
   output logic        m0_ERR_O,

   // master 1: DMA
   input  logic [29:0] m1_ADR_I,
   input  logic        m1_CYC_I,
   input  logic        m1_STB_I,
   input  logic        m1_WE_I,
   input  logic [3:0]  m1_SEL_I,
   input  logic [31:0] m1_DAT_I,
   output logic [31:0] m1_DAT_O,
   output logic        m1_ACK_O,
   output logic        m1_RTY_O,
   output logic        m1_ERR_O,

   // shared slave bus
   output logic [29:0] s_ADR_O,
   output logic        s_CYC_O,
   output logic        s_STB_O,
   output logic        s_WE_O,
   output logic [3:0]  s_SEL_O,
   output logic [31:0] s_DAT_O,
   input  logic [31:0] s_DAT_I,
   input  logic        s_ACK_I,
   input  logic        s_RTY_I,
   input  logic        s_ERR_I,

   output logic        cpu_space_cycle
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

   state_t      state;
   logic        last_grant;   // master that owned the bus most recently
   logic [15:0] wd_cnt;
   logic        wd_err;
   logic        gnt0;
   logic        gnt1;
   logic        stb_sel;      // granted master's strobe before watchdog masking
   logic        wd_clear;

   assign gnt0 = (state == GNT0);
   assign gnt1 = (state == GNT1);

   // Grant FSM: round-robin on ties, no preemption, IDLE between owners.
   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking assignments here would create ordering races.
   always_ff @(posedge CLK_I) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (m0_CYC_I && m1_CYC_I) state <= last_grant ? GNT0 : GNT1;
               else if (m0_CYC_I)        state <= GNT0;
               else if (m1_CYC_I)        state <= GNT1;
            end
            GNT0: begin
               if (!m0_CYC_I) begin
                  state      <= IDLE;
                  last_grant <= 1'b0;
               end
            end
            GNT1: begin
               if (!m1_CYC_I) begin
                  state      <= IDLE;
                  last_grant <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Shared-bus mux selected by the registered grant; all zero in IDLE.
   // NOTE: every output gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      s_ADR_O = '0;
      s_CYC_O = 1'b0;
      stb_sel = 1'b0;
      s_WE_O  = 1'b0;
      s_SEL_O = '0;
      s_DAT_O = '0;
      if (gnt0) begin
         s_ADR_O = m0_ADR_I;
         s_CYC_O = m0_CYC_I;
         stb_sel = m0_STB_I;
         s_WE_O  = m0_WE_I;
         s_SEL_O = m0_SEL_I;
         s_DAT_O = m0_DAT_I;
      end else if (gnt1) begin
         s_ADR_O = m1_ADR_I;
         s_CYC_O = m1_CYC_I;
         stb_sel = m1_STB_I;
         s_WE_O  = m1_WE_I;
         s_SEL_O = m1_SEL_I;
         s_DAT_O = m1_DAT_I;
      end
   end

   // A pending watchdog ERR abandons the cycle toward the slaves.
   assign s_STB_O = stb_sel & ~wd_err;

   // Return path: only the owning master sees data and terminations.
   assign m0_DAT_O = gnt0 ? s_DAT_I : '0;
   assign m0_ACK_O = gnt0 & s_ACK_I;
   assign m0_RTY_O = gnt0 & s_RTY_I;
   assign m0_ERR_O = gnt0 & (s_ERR_I | wd_err);

   assign m1_DAT_O = gnt1 ? s_DAT_I : '0;
   assign m1_ACK_O = gnt1 & s_ACK_I;
   assign m1_RTY_O = gnt1 & s_RTY_I;
   assign m1_ERR_O = gnt1 & (s_ERR_I | wd_err);

   assign cpu_space_cycle = gnt0 & m0_cpu_space;

   // Any slave termination, an idle bus or a dropped strobe restarts the count.
   assign wd_clear = (state == IDLE) | ~s_STB_O | s_ACK_I | s_RTY_I | s_ERR_I;

   // Watchdog: count unanswered strobe cycles, fire a one-cycle ERR at the limit.
   always_ff @(posedge CLK_I) begin
      if (!reset_n) begin
         wd_cnt <= '0;
         wd_err <= 1'b0;
      end else begin
         wd_err <= 1'b0;
         if (wd_clear) begin
            wd_cnt <= '0;
         end else if (wd_cnt == WD_LIMIT) begin
            wd_cnt <= '0;
            wd_err <= 1'b1;
         end else begin
            wd_cnt <= wd_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter (TIMEOUT=4): a per-cycle vector table
// with hand-computed grant and termination columns, plus a hand-written
// watchdog latency sequence.

module tb_wb_master_arbiter;

   localparam logic [29:0] A_T1  = 30'h003C0000;  // byte address 0x00F00000
   localparam logic [29:0] A_CS  = 30'h3FFFFFF8;
   localparam logic [29:0] A_M1  = 30'h00000100;
   localparam logic [31:0] SDAT  = 32'hCAFEF00D;
   localparam logic [31:0] D_M0  = 32'h11111111;
   localparam logic [31:0] D_M1  = 32'h22222222;
   localparam logic [3:0]  SEL0  = 4'hF;
   localparam logic [3:0]  SEL1  = 4'h3;

   logic        CLK_I = 1'b0;
   logic        reset_n;
   logic [29:0] m0_ADR_I;
   logic        m0_CYC_I, m0_STB_I, m0_WE_I, m0_cpu_space;
   logic [3:0]  m0_SEL_I;
   logic [31:0] m0_DAT_I, m0_DAT_O;
   logic        m0_ACK_O, m0_RTY_O, m0_ERR_O;
   logic [29:0] m1_ADR_I;
   logic        m1_CYC_I, m1_STB_I, m1_WE_I;
   logic [3:0]  m1_SEL_I;
   logic [31:0] m1_DAT_I, m1_DAT_O;
   logic        m1_ACK_O, m1_RTY_O, m1_ERR_O;
   logic [29:0] s_ADR_O;
   logic        s_CYC_O, s_STB_O, s_WE_O;
   logic [3:0]  s_SEL_O;
   logic [31:0] s_DAT_O, s_DAT_I;
   logic        s_ACK_I, s_RTY_I, s_ERR_I;
   logic        cpu_space_cycle;

   wb_master_arbiter #(.TIMEOUT(4)) dut (
      .CLK_I(CLK_I), .reset_n(reset_n),
      .m0_ADR_I(m0_ADR_I), .m0_CYC_I(m0_CYC_I), .m0_STB_I(m0_STB_I),
      .m0_WE_I(m0_WE_I), .m0_SEL_I(m0_SEL_I), .m0_DAT_I(m0_DAT_I),
      .m0_cpu_space(m0_cpu_space), .m0_DAT_O(m0_DAT_O),
      .m0_ACK_O(m0_ACK_O), .m0_RTY_O(m0_RTY_O), .m0_ERR_O(m0_ERR_O),
      .m1_ADR_I(m1_ADR_I), .m1_CYC_I(m1_CYC_I), .m1_STB_I(m1_STB_I),
      .m1_WE_I(m1_WE_I), .m1_SEL_I(m1_SEL_I), .m1_DAT_I(m1_DAT_I),
      .m1_DAT_O(m1_DAT_O),
      .m1_ACK_O(m1_ACK_O), .m1_RTY_O(m1_RTY_O), .m1_ERR_O(m1_ERR_O),
      .s_ADR_O(s_ADR_O), .s_CYC_O(s_CYC_O), .s_STB_O(s_STB_O),
      .s_WE_O(s_WE_O), .s_SEL_O(s_SEL_O), .s_DAT_O(s_DAT_O),
      .s_DAT_I(s_DAT_I), .s_ACK_I(s_ACK_I), .s_RTY_I(s_RTY_I),
      .s_ERR_I(s_ERR_I), .cpu_space_cycle(cpu_space_cycle)
   );

   always #5 CLK_I = ~CLK_I;

   // in : {rst_n, m0 cyc stb cpu_space, m1 cyc stb, ack rty err}
   // exp: {grant(0 none,1 m0,2 m1), s_stb, m0 ack rty err, m1 ack rty err, cpu_space_cycle}
   typedef struct {
      string       name;
      logic [29:0] adr0;
      logic [8:0]  in;
      logic [9:0]  exp;
   } vec_t;

   vec_t tab[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic vec_t v(input string nm, input logic [29:0] a0,
                              input logic [8:0] i, input logic [9:0] e);
      vec_t r;
      r.name = nm; r.adr0 = a0; r.in = i; r.exp = e;
      return r;
   endfunction

   task automatic check(input string name, input logic [139:0] act, input logic [139:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic logic [139:0] observed();
      return {s_CYC_O, s_ADR_O, s_SEL_O, s_WE_O, s_DAT_O, s_STB_O, m0_DAT_O, m1_DAT_O,
              m0_ACK_O, m0_RTY_O, m0_ERR_O, m1_ACK_O, m1_RTY_O, m1_ERR_O, cpu_space_cycle};
   endfunction

   // Expected bus fields follow from the hand-set grant column and the row's inputs.
   function automatic logic [139:0] expected(input vec_t r);
      logic [1:0]  g;
      logic        cyc, we;
      logic [29:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat, d0, d1;
      g   = r.exp[9:8];
      cyc = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0; d0 = '0; d1 = '0;
      if (g == 2'd1) begin
         cyc = r.in[7]; adr = r.adr0; sel = SEL0; we = 1'b0; dat = D_M0; d0 = SDAT;
      end else if (g == 2'd2) begin
         cyc = r.in[4]; adr = A_M1; sel = SEL1; we = 1'b1; dat = D_M1; d1 = SDAT;
      end
      return {cyc, adr, sel, we, dat, r.exp[7], d0, d1, r.exp[6:0]};
   endfunction

   task automatic drive(input vec_t r);
      reset_n      = r.in[8];
      m0_ADR_I     = r.adr0;
      m0_CYC_I     = r.in[7];
      m0_STB_I     = r.in[6];
      m0_cpu_space = r.in[5];
      m1_CYC_I     = r.in[4];
      m1_STB_I     = r.in[3];
      s_ACK_I      = r.in[2];
      s_RTY_I      = r.in[1];
      s_ERR_I      = r.in[0];
   endtask

   initial begin
      int   rise, errc;
      logic stb_at;

      // reset: simultaneous request, both grant orders
      tab.push_back(v("reset",       A_T1, 9'b0_000_00_000, 10'b00_0_000_000_0));
      tab.push_back(v("t1_req",      A_T1, 9'b1_110_00_000, 10'b00_0_000_000_0));
      tab.push_back(v("t1_wait",     A_T1, 9'b1_110_00_000, 10'b01_1_000_000_0));
      tab.push_back(v("t1_ack",      A_T1, 9'b1_110_00_100, 10'b01_1_100_000_0));
      tab.push_back(v("t1_rel",      A_T1, 9'b1_000_00_000, 10'b01_0_000_000_0));
      tab.push_back(v("t1_idle",     A_T1, 9'b1_000_00_000, 10'b00_0_000_000_0));
      tab.push_back(v("t2_rst",      A_T1, 9'b0_000_00_000, 10'b00_0_000_000_0));
      tab.push_back(v("t2_both",     A_T1, 9'b1_110_11_000, 10'b00_0_000_000_0));
      tab.push_back(v("t2_m0ack",    A_T1, 9'b1_110_11_100, 10'b01_1_100_000_0));
      tab.push_back(v("t2_m0drop",   A_T1, 9'b1_000_11_000, 10'b01_0_000_000_0));
      tab.push_back(v("t2_gap",      A_T1, 9'b1_000_11_000, 10'b00_0_000_000_0));
      tab.push_back(v("t2_m1ack",    A_T1, 9'b1_000_11_100, 10'b10_1_000_100_0));
      tab.push_back(v("t2_m1drop",   A_T1, 9'b1_000_00_000, 10'b10_0_000_000_0));
      tab.push_back(v("t2_both2",    A_T1, 9'b1_110_11_000, 10'b00_0_000_000_0));
      tab.push_back(v("t2_m0ack2",   A_T1, 9'b1_110_11_100, 10'b01_1_100_000_0));
      tab.push_back(v("t2_m0drop2",  A_T1, 9'b1_000_11_000, 10'b01_0_000_000_0));
      tab.push_back(v("t2_gap2",     A_T1, 9'b1_000_11_000, 10'b00_0_000_000_0));
      tab.push_back(v("t2_m1ack2",   A_T1, 9'b1_000_11_100, 10'b10_1_000_100_0));
      tab.push_back(v("t2_m1drop2",  A_T1, 9'b1_000_00_000, 10'b10_0_000_000_0));
      // CPU space cycle with RTY, then m1 owning while m0_cpu_space stays high
      tab.push_back(v("t3_req",      A_CS, 9'b1_111_00_000, 10'b00_0_000_000_0));
      tab.push_back(v("t3_cs",       A_CS, 9'b1_111_00_000, 10'b01_1_000_000_1));
      tab.push_back(v("t3_rty",      A_CS, 9'b1_111_00_010, 10'b01_1_010_000_1));
      tab.push_back(v("t3_drop",     A_CS, 9'b1_001_00_000, 10'b01_0_000_000_1));
      tab.push_back(v("t3_m1req",    A_CS, 9'b1_001_11_000, 10'b00_0_000_000_0));
      tab.push_back(v("t3_m1err",    A_CS, 9'b1_001_11_001, 10'b10_1_000_001_0));
      tab.push_back(v("t3_m1drop",   A_CS, 9'b1_001_00_000, 10'b10_0_000_000_0));
      // watchdog: no response, ERR 4 cycles after the strobe rose
      tab.push_back(v("t4_req",      A_T1, 9'b1_000_11_000, 10'b00_0_000_000_0));
      tab.push_back(v("t4_cnt0",     A_T1, 9'b1_000_11_000, 10'b10_1_000_000_0));
      tab.push_back(v("t4_cnt1",     A_T1, 9'b1_000_11_000, 10'b10_1_000_000_0));
      tab.push_back(v("t4_cnt2",     A_T1, 9'b1_000_11_000, 10'b10_1_000_000_0));
      tab.push_back(v("t4_cnt3",     A_T1, 9'b1_000_11_000, 10'b10_1_000_000_0));
      tab.push_back(v("t4_wderr",    A_T1, 9'b1_000_11_000, 10'b10_0_000_001_0));
      tab.push_back(v("t4_drop",     A_T1, 9'b1_000_00_000, 10'b10_0_000_000_0));
      // ACK on exactly the 4th cycle beats the watchdog
      tab.push_back(v("t5_req",      A_T1, 9'b1_000_11_000, 10'b00_0_000_000_0));
      tab.push_back(v("t5_cnt0",     A_T1, 9'b1_000_11_000, 10'b10_1_000_000_0));
      tab.push_back(v("t5_cnt1",     A_T1, 9'b1_000_11_000, 10'b10_1_000_000_0));
      tab.push_back(v("t5_cnt2",     A_T1, 9'b1_000_11_000, 10'b10_1_000_000_0));
      tab.push_back(v("t5_ack4",     A_T1, 9'b1_000_11_100, 10'b10_1_000_100_0));
      tab.push_back(v("t5_noerr",    A_T1, 9'b1_000_11_000, 10'b10_1_000_000_0));
      tab.push_back(v("t5_drop",     A_T1, 9'b1_000_00_000, 10'b10_0_000_000_0));
      // CYC dropped while the watchdog fires: ERR must be masked in IDLE
      tab.push_back(v("t6_req",      A_T1, 9'b1_000_11_000, 10'b00_0_000_000_0));
      tab.push_back(v("t6_cnt0",     A_T1, 9'b1_000_11_000, 10'b10_1_000_000_0));
      tab.push_back(v("t6_cnt1",     A_T1, 9'b1_000_11_000, 10'b10_1_000_000_0));
      tab.push_back(v("t6_cnt2",     A_T1, 9'b1_000_11_000, 10'b10_1_000_000_0));
      tab.push_back(v("t6_dropcyc",  A_T1, 9'b1_000_01_000, 10'b10_1_000_000_0));
      tab.push_back(v("t6_masked",   A_T1, 9'b1_000_00_000, 10'b00_0_000_000_0));
      // reset mid-burst of m1, then m0 wins the tie
      tab.push_back(v("t7_req",      A_T1, 9'b1_000_11_000, 10'b00_0_000_000_0));
      tab.push_back(v("t7_ack",      A_T1, 9'b1_000_11_100, 10'b10_1_000_100_0));
      tab.push_back(v("t7_rst",      A_T1, 9'b0_000_11_000, 10'b10_1_000_000_0));
      tab.push_back(v("t7_both",     A_T1, 9'b1_110_11_000, 10'b00_0_000_000_0));
      tab.push_back(v("t7_m0ack",    A_T1, 9'b1_110_11_100, 10'b01_1_100_000_0));
      tab.push_back(v("t7_m0drop",   A_T1, 9'b1_000_00_000, 10'b01_0_000_000_0));
      tab.push_back(v("t7_idle",     A_T1, 9'b1_000_00_000, 10'b00_0_000_000_0));

      // static master payloads and slave read data
      m0_WE_I = 1'b0; m0_SEL_I = SEL0; m0_DAT_I = D_M0;
      m1_WE_I = 1'b1; m1_SEL_I = SEL1; m1_DAT_I = D_M1; m1_ADR_I = A_M1;
      s_DAT_I = SDAT;
      drive(v("init", A_T1, 9'b0_000_00_000, 10'b0));
      repeat (2) @(posedge CLK_I);
      #2;

      // inputs change 2 units after the edge, outputs sampled mid-cycle
      foreach (tab[i]) begin
         drive(tab[i]);
         #3;
         check(tab[i].name, observed(), expected(tab[i]));
         @(posedge CLK_I);
         #2;
      end

      // Watchdog latency measured directly: bounded wait for the ERR pulse.
      drive(v("wd", A_T1, 9'b1_000_11_000, 10'b0));
      rise   = -1;
      errc   = -1;
      stb_at = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #3;
         if (rise < 0 && s_STB_O) rise = k;
         if (m1_ERR_O) begin
            errc   = k;
            stb_at = s_STB_O;
            break;
         end
         @(posedge CLK_I);
         #2;
      end
      if (errc < 0) $display("FAIL wd_wait: no m1_ERR_O within 20 cycles");
      check("wd_first_stb", 140'(rise), 140'(1));
      check("wd_latency",   140'(errc - rise), 140'(4));
      check("wd_stb_gated", 140'(stb_at), 140'(0));
      @(posedge CLK_I);
      #5;
      check("wd_pulse_width", 140'(m1_ERR_O), 140'(0));
      check("wd_stb_resumes", 140'(s_STB_O), 140'(1));
      drive(v("wd_end", A_T1, 9'b1_000_00_000, 10'b0));
      repeat (2) @(posedge CLK_I);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Two-master WISHBONE arbiter that merges the ao68000 CPU bus and the secondary DMA master onto the single shared slave bus. The shared bus feeds the address decoder and every slave behind it, including the bus terminator. The block grants the bus to one master per cycle using round-robin priority. It returns the slave's ACK_O, RTY_O and ERR_O to the owning master only. It also drives `cpu_space_cycle` toward the slaves, and it ends stuck cycles with a watchdog ERR.

## Interface
- TIMEOUT, 255: cycles of unanswered CYC&STB before the watchdog ERR fires; legal range 2..65535.
- CLK_I  in  1  system clock; every register updates on its rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- m0_ADR_I  in  30  CPU address [31:2].
- m0_CYC_I, m0_STB_I, m0_WE_I  in  1 each  CPU cycle, strobe and write enable.
- m0_SEL_I  in  4  CPU byte selects.
- m0_DAT_I  in  32  CPU write data.
- m0_cpu_space  in  1  CPU interrupt-acknowledge (CPU space) indicator.
- m0_DAT_O  out  32  read data returned to the CPU.
- m0_ACK_O, m0_RTY_O, m0_ERR_O  out  1 each  terminations returned to the CPU.
- m1_*  same set as m0_*, without m1_cpu_space: the DMA master.
- s_ADR_O  out  30, s_CYC_O/s_STB_O/s_WE_O  out  1, s_SEL_O  out  4, s_DAT_O  out  32: shared bus toward the slaves.
- s_DAT_I  in  32, s_ACK_I/s_RTY_I/s_ERR_I  in  1: merged slave response.
- cpu_space_cycle  out  1  high only while the CPU owns the bus and m0_cpu_space=1.

## Operation
- The FSM has three registered states: IDLE, GNT0, GNT1. Reset puts it in IDLE with last_grant=1, so master 0 wins the first tie.
- IDLE: if exactly one mN_CYC_I is high, go to GNTN. If both are high, grant the master that is not last_grant. If neither is high, stay in IDLE.
- GNTN: stay while mN_CYC_I=1. When mN_CYC_I=0, go to IDLE and set last_grant=N.
- Every handover passes through at least one IDLE cycle. A master is never preempted while its CYC is high.
- Shared bus outputs are a mux of the granted master's signals, selected by registered state. In IDLE all s_* outputs are 0.
- Return path: mN_ACK_O = GNTN & s_ACK_I; mN_RTY_O = GNTN & s_RTY_I. mN_DAT_O = s_DAT_I when GNTN, otherwise 0.
- mN_ERR_O = GNTN & (s_ERR_I | wd_err).
- The non-granted master sees 0 on all of its outputs.
- Watchdog counter, 16 bits:
  - Clears in IDLE, when s_STB_O=0, or when any of s_ACK_I/s_RTY_I/s_ERR_I=1.
  - Otherwise increments.
  - When it equals TIMEOUT-1 with none of those three clear conditions true, wd_err is registered high for exactly one cycle and the counter clears.
  - While wd_err=1, s_STB_O is forced to 0 so slaves see the cycle abandoned.
- If reset_n=0 mid-cycle, the next edge returns the FSM to IDLE, clears the counter and wd_err, and sets last_grant=1.

## Timing
- Reset value of every output is 0. This holds because the FSM is in IDLE and wd_err=0.
- Grant latency is 1 cycle. A request sampled in IDLE at edge k drives s_CYC_O at cycle k+1.
- Response path is combinational, with 0 added latency for ACK/RTY/ERR/DAT.
- Release latency is 1 cycle. Master CYC low at edge k puts the FSM in IDLE at k+1. A waiting master is granted at k+2.
- The watchdog ERR appears TIMEOUT cycles after the first unanswered CYC&STB cycle.
- A slave termination in the same cycle the counter would hit TIMEOUT-1 wins: the counter clears and no wd_err is raised.
- A master that drops CYC while wd_err is pending still gets wd_err gated off, because the FSM has left GNTN and the ERR mask is 0.

## Test plan
- Reset, then m0 issues a read of 0x00F00000 and the slave ACKs on its 2nd bus cycle. Required: s_CYC_O rises 1 cycle after m0_CYC_I; m0_ACK_O and m0_DAT_O equal the slave values; m1 outputs stay 0.
- m0 and m1 both raise CYC in the same cycle after reset. Required: m0 granted first; after m0 drops CYC, 1 IDLE cycle, then m1 granted. Repeat the same simultaneous request: m0 is granted first again, because last_grant=1 after m1's cycle.
- m0 performs a CPU space read of ADR 0x3FFFFFF8 with m0_cpu_space=1, and the slave returns s_RTY_I. Required: cpu_space_cycle=1 throughout GNT0 and m0_RTY_O=1 when the slave asserts RTY; with m1 granted and m0_cpu_space=1, cpu_space_cycle stays 0.
- TIMEOUT=4, m1 strobes and the slave never responds. Required: m1_ERR_O pulses for 1 cycle, 4 cycles after s_STB_O first rose; s_STB_O=0 during the pulse.
- TIMEOUT=4, slave ACKs on exactly the 4th cycle. Required: ACK is delivered and no ERR pulse.
- reset_n=0 for 1 cycle while m1 is mid-burst. Required: all outputs 0 on the next cycle; FSM in IDLE; with both masters requesting afterwards, m0 wins.
